// File: rtl/vga_pkg.sv
// Shared types, colour constants and default 640x480@60 timing for the VGA raster generator.
package vga_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } fsm_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam rgb_t WHITE     = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
   localparam rgb_t BLACK     = '{r: 8'h00, g: 8'h00, b: 8'h00};
   localparam rgb_t LIGHTBLUE = '{r: 8'hAD, g: 8'hD8, b: 8'hE6};
   localparam rgb_t YELLOW    = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
   localparam rgb_t CYAN      = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
   localparam rgb_t GREEN     = '{r: 8'h00, g: 8'hFF, b: 8'h00};
   localparam rgb_t MAGENTA   = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
   localparam rgb_t RED       = '{r: 8'hFF, g: 8'h00, b: 8'h00};
   localparam rgb_t BLUE      = '{r: 8'h00, g: 8'h00, b: 8'hFF};

   // Classic colour-bar order, left to right.
   function automatic rgb_t bar_colour(input logic [2:0] idx);
      rgb_t c;
      c = BLACK;
      case (idx)
         3'd0: c = WHITE;
         3'd1: c = YELLOW;
         3'd2: c = CYAN;
         3'd3: c = GREEN;
         3'd4: c = MAGENTA;
         3'd5: c = RED;
         3'd6: c = BLUE;
         3'd7: c = BLACK;
         default: c = BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-latency shift register with synchronous clear; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ctl;
         assign unused_ctl = clk ^ rst_n;
         assign dout       = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame-boundary start/stop and RGB re-alignment.
// Optional internal colour-bar source selected by macro VGA_TEST_PATTERN_EN.
//
// state    | meaning
// IDLE     | counters held at 0, no requests, outputs drain to inactive
// RUN      | raster counting, i_enable high
// STOPPING | i_enable dropped, finishing the current frame
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int PIPE_LAT = 2,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int X_W     = $clog2(H_TOTAL),
   localparam int Y_W     = $clog2(V_TOTAL)
) (
   input  logic           VGA_CLK_IN,
   input  logic           VGA_RST_N_IN,
   input  logic           i_enable,
   input  logic [7:0]     i_red,
   input  logic [7:0]     i_green,
   input  logic [7:0]     i_blue,
   output logic           o_req,
   output logic [X_W-1:0] o_x,
   output logic [Y_W-1:0] o_y,
   output logic           o_frame_start,
   output logic           o_line_start,
   output logic           o_hsync,
   output logic           o_vsync,
   output logic           o_blank_n,
   output logic [7:0]     o_red,
   output logic [7:0]     o_green,
   output logic [7:0]     o_blue,
   output logic           VGA_CLK_OUT
);

   localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
   localparam logic [X_W-1:0] H_ACT_LAST = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0] V_ACT_LAST = Y_W'(V_ACTIVE - 1);
   localparam logic [X_W-1:0] HS_FIRST   = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0] HS_LAST    = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [Y_W-1:0] VS_FIRST   = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0] VS_LAST    = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   fsm_t           state, state_nxt;
   logic [X_W-1:0] h_cnt;
   logic [Y_W-1:0] v_cnt;
   logic           running, last_pix;
   logic           hs_raw, vs_raw, de_raw;
   logic           hs_d, vs_d, de_d;
   rgb_t           src;

   assign VGA_CLK_OUT = VGA_CLK_IN;

   assign running  = (state != IDLE);
   assign last_pix = (h_cnt == H_LAST) && (v_cnt == V_LAST);

   always_ff @(posedge VGA_CLK_IN) begin
      if (!VGA_RST_N_IN) state <= IDLE;
      else               state <= state_nxt;
   end

   // A re-raised enable on the final pixel keeps the raster running seamlessly.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (i_enable) state_nxt = RUN;
         RUN:      if (!i_enable) state_nxt = STOPPING;
         STOPPING: begin
            if (i_enable)      state_nxt = RUN;
            else if (last_pix) state_nxt = IDLE;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge VGA_CLK_IN) begin
      if (!VGA_RST_N_IN || !running) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + Y_W'(1);
      end else begin
         h_cnt <= h_cnt + X_W'(1);
      end
   end

   assign hs_raw = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
   assign vs_raw = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
   assign de_raw = running && (h_cnt <= H_ACT_LAST) && (v_cnt <= V_ACT_LAST);

   assign o_req         = de_raw;
   assign o_x           = h_cnt;
   assign o_y           = v_cnt;
   assign o_frame_start = running && (h_cnt == '0) && (v_cnt == '0);
   assign o_line_start  = running && (h_cnt == '0);

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;

   logic [X_W-1:0] bar_full;
   rgb_t           pat_raw;
   logic [26:0]    dl_out;
   logic           unused_ext;

   assign bar_full   = h_cnt / X_W'(BAR_W);
   assign pat_raw    = bar_colour(bar_full[2:0]);
   assign unused_ext = ^{i_red, i_green, i_blue, bar_full};

   // Bar colour rides the same delay as sync so alignment matches the external path.
   vga_delay_line #(.WIDTH(27), .DEPTH(PIPE_LAT)) u_dly (
      .clk   (VGA_CLK_IN),
      .rst_n (VGA_RST_N_IN),
      .din   ({hs_raw, vs_raw, de_raw, pat_raw}),
      .dout  (dl_out)
   );

   assign {hs_d, vs_d, de_d} = dl_out[26:24];
   assign src                = dl_out[23:0];
`else
   logic [2:0] dl_out;

   vga_delay_line #(.WIDTH(3), .DEPTH(PIPE_LAT)) u_dly (
      .clk   (VGA_CLK_IN),
      .rst_n (VGA_RST_N_IN),
      .din   ({hs_raw, vs_raw, de_raw}),
      .dout  (dl_out)
   );

   assign {hs_d, vs_d, de_d} = dl_out;
   assign src                = '{r: i_red, g: i_green, b: i_blue};
`endif

   always_ff @(posedge VGA_CLK_IN) begin
      if (!VGA_RST_N_IN) begin
         o_hsync   <= ~HS_POL;
         o_vsync   <= ~VS_POL;
         o_blank_n <= 1'b0;
         o_red     <= '0;
         o_green   <= '0;
         o_blue    <= '0;
      end else begin
         o_hsync   <= hs_d ~^ HS_POL;
         o_vsync   <= vs_d ~^ VS_POL;
         o_blank_n <= de_d;
         o_red     <= de_d ? src.r : 8'h00;
         o_green   <= de_d ? src.g : 8'h00;
         o_blue    <= de_d ? src.b : 8'h00;
      end
   end

endmodule
